// File: rtl/inst_cache_pkg.sv
// Shared configuration and types for the L1 instruction cache.
// Holds the default geometry (RV_ICACHE_BLOCKS / RV_ICACHE_SETS), the
// address and instruction types, the address-field typedefs for the default
// geometry and the cache FSM state enum.
package inst_cache_pkg;

  localparam int RV_ICACHE_BLOCKS = 4;
  localparam int RV_ICACHE_SETS   = 64;

  localparam int INST_ADDR_W = 32;
  localparam int INST_W      = 32;

  typedef logic [INST_ADDR_W-1:0] InstAddr;
  typedef logic [INST_W-1:0]      Inst;

  localparam int ICACHE_OFF_W = 2 + $clog2(RV_ICACHE_BLOCKS);
  localparam int ICACHE_IDX_W = $clog2(RV_ICACHE_SETS);
  localparam int ICACHE_TAG_W = INST_ADDR_W - ICACHE_OFF_W - ICACHE_IDX_W;

  typedef logic [ICACHE_TAG_W-1:0] ICacheTag;
  typedef logic [ICACHE_IDX_W-1:0] ICacheIndex;
  typedef logic [ICACHE_OFF_W-1:0] ICacheOffset;

  typedef enum logic [1:0] {
    ICS_INVAL = 2'd0,
    ICS_IDLE  = 2'd1,
    ICS_FILL  = 2'd2,
    ICS_DONE  = 2'd3
  } ICacheState;

endpackage

// File: rtl/inst_cache_tag_ram.sv
// Tag + valid storage for the instruction cache.
// Ports:
//   clk_i      clock
//   rd_idx_i   read index (combinational read)
//   rd_tag_o   stored tag at rd_idx_i
//   rd_valid_o valid bit at rd_idx_i
//   wr_en_i    write tag at wr_idx_i and set its valid bit
//   wr_idx_i / wr_tag_i  write index / tag
//   clr_en_i   clear the valid bit at clr_idx_i
// The arrays are not reset; the owning FSM sweeps the valid bits after reset.
module inst_cache_tag_ram #(
  parameter int SETS  = 64,
  parameter int TAG_W = 22
) (
  input  logic                     clk_i,
  input  logic [$clog2(SETS)-1:0]  rd_idx_i,
  output logic [TAG_W-1:0]         rd_tag_o,
  output logic                     rd_valid_o,
  input  logic                     wr_en_i,
  input  logic [$clog2(SETS)-1:0]  wr_idx_i,
  input  logic [TAG_W-1:0]         wr_tag_i,
  input  logic                     clr_en_i,
  input  logic [$clog2(SETS)-1:0]  clr_idx_i
);

  logic [TAG_W-1:0] tag_q [SETS];
  logic [SETS-1:0]  valid_q;

  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_valid_o = valid_q[rd_idx_i];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      tag_q[wr_idx_i]   <= wr_tag_i;
      valid_q[wr_idx_i] <= 1'b1;
    end
    if (clr_en_i) begin
      valid_q[clr_idx_i] <= 1'b0;
    end
  end

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped L1 instruction cache. Returns a whole line per lookup with
// zero-latency hits; misses fill the line with sequential single-word reads.
// Ports:
//   i_clock, i_reset      clock, async active-high reset
//   i_addr, i_re          fetch address / lookup request
//   o_inst, o_busy        line contents / result not valid this cycle
//   i_flush               invalidate-all pulse
//   o_mem_addr, o_mem_re  memory word address / read request
//   i_mem_data, i_mem_ack memory read data / data valid
// Optional: RV_ICACHE_STATS_EN adds o_hit_count / o_miss_count.
//
// state | meaning
// INVAL | sweep clears one valid bit per cycle
// IDLE  | serve lookups, start fill on miss
// FILL  | read line words from memory
// DONE  | write tag, set valid
module inst_cache
  import inst_cache_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32,
  parameter int BLOCKS     = RV_ICACHE_BLOCKS,
  parameter int SETS       = RV_ICACHE_SETS
) (
  input  logic                             i_clock,
  input  logic                             i_reset,
  input  logic [ADDR_WIDTH-1:0]            i_addr,
  input  logic                             i_re,
  output logic [BLOCKS-1:0][INST_WIDTH-1:0] o_inst,
  output logic                             o_busy,
  input  logic                             i_flush,
  output logic [ADDR_WIDTH-1:0]            o_mem_addr,
  output logic                             o_mem_re,
  input  logic [INST_WIDTH-1:0]            i_mem_data,
  input  logic                             i_mem_ack
`ifdef RV_ICACHE_STATS_EN
  ,
  output logic [31:0]                      o_hit_count,
  output logic [31:0]                      o_miss_count
`endif
);

  localparam int WORD_W = $clog2(BLOCKS);
  localparam int OFF_W  = 2 + WORD_W;
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_WIDTH - OFF_W - IDX_W;
  localparam int LINE_W = TAG_W + IDX_W;

  ICacheState        state_q, state_d;
  logic [IDX_W-1:0]  sweep_q, sweep_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic              flush_pend_q, flush_pend_d;

  logic [IDX_W-1:0]  req_idx, line_idx;
  logic [TAG_W-1:0]  req_tag, rd_tag;
  logic              rd_valid, hit, fill_wr;

  logic [BLOCKS-1:0][INST_WIDTH-1:0] data_q [SETS];

  assign req_idx  = i_addr[OFF_W +: IDX_W];
  assign req_tag  = i_addr[ADDR_WIDTH-1 -: TAG_W];
  assign line_idx = line_q[IDX_W-1:0];

  assign hit        = i_re && (state_q == ICS_IDLE) && rd_valid && (rd_tag == req_tag);
  assign o_busy     = (i_re && !hit) || (state_q != ICS_IDLE);
  assign o_mem_re   = (state_q == ICS_FILL);
  assign o_mem_addr = o_mem_re ? {line_q, word_q, 2'b00} : '0;
  assign fill_wr    = o_mem_re && i_mem_ack;
  assign o_inst     = data_q[req_idx];

  // The line being refilled is invalidated on every word write so a
  // conflict refill never exposes a mix of old tag and new data.
  inst_cache_tag_ram #(.SETS(SETS), .TAG_W(TAG_W)) u_tag_ram (
    .clk_i      (i_clock),
    .rd_idx_i   (req_idx),
    .rd_tag_o   (rd_tag),
    .rd_valid_o (rd_valid),
    .wr_en_i    (state_q == ICS_DONE),
    .wr_idx_i   (line_idx),
    .wr_tag_i   (line_q[LINE_W-1 -: TAG_W]),
    .clr_en_i   ((state_q == ICS_INVAL) || fill_wr),
    .clr_idx_i  ((state_q == ICS_INVAL) ? sweep_q : line_idx)
  );

  always_ff @(posedge i_clock) begin
    if (fill_wr) begin
      data_q[line_idx][word_q] <= i_mem_data;
    end
  end

  always_comb begin
    state_d      = state_q;
    sweep_d      = sweep_q;
    word_d       = word_q;
    line_d       = line_q;
    flush_pend_d = flush_pend_q;
    unique case (state_q)
      ICS_INVAL: begin
        if (i_flush) begin
          sweep_d = '0;
        end else if (sweep_q == IDX_W'(SETS - 1)) begin
          state_d = ICS_IDLE;
        end else begin
          sweep_d = sweep_q + 1'b1;
        end
      end
      ICS_IDLE: begin
        if (i_flush) begin
          state_d      = ICS_INVAL;
          sweep_d      = '0;
          flush_pend_d = 1'b0;
        end else if (i_re && !hit) begin
          state_d = ICS_FILL;
          line_d  = i_addr[ADDR_WIDTH-1:OFF_W];
          word_d  = '0;
        end
      end
      ICS_FILL: begin
        if (i_flush) flush_pend_d = 1'b1;
        if (i_mem_ack) begin
          word_d = word_q + 1'b1;
          if (word_q == WORD_W'(BLOCKS - 1)) state_d = ICS_DONE;
        end
      end
      ICS_DONE: begin
        if (flush_pend_q || i_flush) begin
          state_d      = ICS_INVAL;
          sweep_d      = '0;
          flush_pend_d = 1'b0;
        end else begin
          state_d = ICS_IDLE;
        end
      end
      default: state_d = ICS_INVAL;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= ICS_INVAL;
      sweep_q      <= '0;
      word_q       <= '0;
      line_q       <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sweep_q      <= sweep_d;
      word_q       <= word_d;
      line_q       <= line_d;
      flush_pend_q <= flush_pend_d;
    end
  end

`ifdef RV_ICACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit) hit_cnt_q <= hit_cnt_q + 1'b1;
      if ((state_q == ICS_IDLE) && (state_d == ICS_FILL)) miss_cnt_q <= miss_cnt_q + 1'b1;
    end
  end

  assign o_hit_count  = hit_cnt_q;
  assign o_miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_inst_cache.sv
// Directed self-checking bench for inst_cache (BLOCKS=4, SETS=64).
// Memory model: data = address ^ 0xA5A5A5A5, ack after `lat` wait cycles.
module tb_inst_cache;
  import inst_cache_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [31:0]       addr = '0;
  logic              re = 1'b0;
  logic              flush = 1'b0;
  logic [3:0][31:0]  inst;
  logic              busy;
  logic [31:0]       mem_addr, mem_data;
  logic              mem_re, mem_ack;
`ifdef RV_ICACHE_STATS_EN
  logic [31:0]       hit_count, miss_count;
`endif

  int          checks = 0;
  int          errors = 0;
  int          lat = 0;
  int          wcnt = 0;
  logic [31:0] q[$];

  always #5 clk = ~clk;

  assign mem_data = mem_addr ^ 32'hA5A5A5A5;
  assign mem_ack  = mem_re && (wcnt == lat);

  always @(posedge clk or posedge rst) begin
    if (rst) wcnt <= 0;
    else if (mem_ack || !mem_re) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  inst_cache dut (
    .i_clock    (clk),
    .i_reset    (rst),
    .i_addr     (addr),
    .i_re       (re),
    .o_inst     (inst),
    .o_busy     (busy),
    .i_flush    (flush),
    .o_mem_addr (mem_addr),
    .o_mem_re   (mem_re),
    .i_mem_data (mem_data),
    .i_mem_ack  (mem_ack)
`ifdef RV_ICACHE_STATS_EN
    ,
    .o_hit_count  (hit_count),
    .o_miss_count (miss_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue a lookup and count sampled cycles until busy clears; records
  // every address presented while o_mem_re is high.
  task automatic lookup(input logic [31:0] a, output int cyc);
    @(negedge clk); addr = a; re = 1'b1; #1;
    cyc = 0; q.delete();
    while (busy && cyc < 500) begin
      if (mem_re) q.push_back(mem_addr);
      @(negedge clk); #1; cyc++;
    end
  endtask

  // Release reset with a lookup pending; count cycles without a memory
  // request (sweep + miss detect) and the total cycles until the hit.
  task automatic sweep_fill(input logic [31:0] a, output int nore,
                            output logic busy_all, output int total);
    @(negedge clk); addr = a; re = 1'b1; rst = 1'b0; #1;
    nore = 0; busy_all = 1'b1; q.delete();
    while (!mem_re && nore < 200) begin
      if (!busy) busy_all = 1'b0;
      nore++;
      @(negedge clk); #1;
    end
    total = nore;
    while (busy && total < 400) begin
      if (mem_re) q.push_back(mem_addr);
      @(negedge clk); #1; total++;
    end
  endtask

  initial begin
    int          cyc, nore, total;
    logic        busy_all;
    logic [31:0] qv;

    // Async reset before any clock edge
    #1 rst = 1'b1;
    #1;
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_mem_re", 32'(mem_re), 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_state", 32'(dut.state_q), 32'(ICS_INVAL));
    repeat (3) @(negedge clk);

    // Sweep of 64 cycles then miss at 0x0
    sweep_fill(32'h0, nore, busy_all, total);
    check("sweep_no_mem_re", 32'(nore), 32'd65);
    check("sweep_busy", 32'(busy_all), 32'd1);
    check("sweep_total", 32'(total), 32'd70);
    qv = (q.size() > 0) ? q[0] : 32'hFFFFFFFF;
    check("sweep_first_addr", qv, 32'h0);
    check("sweep_inst0", inst[0], 32'hA5A5A5A5);

    // Cold miss at 0x100
    lookup(32'h100, cyc);
    check("cold_cycles", 32'(cyc), 32'd6);
    check("cold_nreq", 32'(q.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      qv = (i < q.size()) ? q[i] : 32'hFFFFFFFF;
      check("cold_mem_addr", qv, 32'h100 + 32'(i * 4));
    end
    check("cold_inst0", inst[0], 32'hA5A5A4A5);
    check("cold_inst1", inst[1], 32'hA5A5A4A1);
    check("cold_inst2", inst[2], 32'hA5A5A4AD);
    check("cold_inst3", inst[3], 32'hA5A5A4A9);
    lookup(32'h108, cyc);
    check("hit_cycles", 32'(cyc), 32'd0);
    check("hit_busy", 32'(busy), 32'd0);
    check("hit_inst2", inst[2], 32'hA5A5A4AD);

    // Conflict on index 16
    lookup(32'h500, cyc);
    check("conf_cycles", 32'(cyc), 32'd6);
    check("conf_inst0", inst[0], 32'hA5A5A0A5);
    lookup(32'h100, cyc);
    check("conf_back_cycles", 32'(cyc), 32'd6);
    check("conf_back_inst1", inst[1], 32'hA5A5A4A1);

    // Three wait cycles per word
    lat = 3;
    lookup(32'h200, cyc);
    check("lat_cycles", 32'(cyc), 32'd18);
    check("lat_nreq", 32'(q.size()), 32'd16);
    for (int i = 0; i < 16; i++) begin
      qv = (i < q.size()) ? q[i] : 32'hFFFFFFFF;
      check("lat_mem_addr", qv, 32'h200 + 32'((i / 4) * 4));
    end
    check("lat_inst3", inst[3], 32'hA5A5A7A9);
    lat = 0;

    // Flush during second fill word; request dropped mid-fill
    @(negedge clk); addr = 32'h300; re = 1'b1; #1;
    @(negedge clk); re = 1'b0; addr = 32'h0; #1;
    @(negedge clk); flush = 1'b1; #1;
    check("flush_word1_addr", mem_addr, 32'h304);
    @(negedge clk); flush = 1'b0; #1;
    cyc = 3;
    while (busy && cyc < 300) begin
      @(negedge clk); #1; cyc++;
    end
    check("flush_busy_cycles", 32'(cyc), 32'd70);
    lookup(32'h100, cyc);
    check("flush_100_miss", 32'(cyc), 32'd6);
    lookup(32'h300, cyc);
    check("flush_300_miss", 32'(cyc), 32'd6);
    check("flush_300_inst0", inst[0], 32'hA5A5A6A5);

    // Async reset mid-fill of 0x400
    @(negedge clk); addr = 32'h400; re = 1'b1; #1;
    @(negedge clk); #1;
    @(negedge clk); #1;
    check("mid_mem_addr", mem_addr, 32'h404);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_mem_re", 32'(mem_re), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd1);
    check("mid_rst_mem_addr", mem_addr, 32'h0);
    repeat (2) @(negedge clk);
    sweep_fill(32'h400, nore, busy_all, total);
    check("re_sweep_no_mem_re", 32'(nore), 32'd65);
    check("re_sweep_total", 32'(total), 32'd70);
    qv = (q.size() > 0) ? q[0] : 32'hFFFFFFFF;
    check("re_first_addr", qv, 32'h400);
    check("re_inst0", inst[0], 32'hA5A5A1A5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_cache.md
Name: inst_cache

Overview:
- Direct-mapped L1 instruction cache; slave side of the instruction cache bus, sitting between the fetch stage (master) and the instruction memory port.
- Returns a full line of instructions per lookup.
- On a miss, fills the line with sequential single-word reads from memory.
- Supports whole-cache invalidate after reset and on flush request.

Parameters:
- ADDR_WIDTH, 32, byte address width (matches InstAddr).
- INST_WIDTH, 32, instruction width (matches Inst).
- BLOCKS, RV_ICACHE_BLOCKS (4), instructions per line; power of two, ≥2.
- SETS, RV_ICACHE_SETS (64), number of lines; power of two, ≥2.

Ports:
- i_clock  in  1  clock, rising edge
- i_reset  in  1  reset, asynchronous, active-high
- i_addr  in  ADDR_WIDTH  fetch address (bus addr)
- i_re  in  1  lookup request (bus re)
- o_inst  out  BLOCKS x INST_WIDTH  line contents, element k = word k of line (bus inst)
- o_busy  out  1  result not valid this cycle (bus busy)
- i_flush  in  1  invalidate-all request, single-cycle pulse
- o_mem_addr  out  ADDR_WIDTH  word address to memory, bits[1:0]=0
- o_mem_re  out  1  memory read request
- i_mem_data  in  INST_WIDTH  memory read data
- i_mem_ack  in  1  read data valid; sampled only while o_mem_re=1

Behaviour:
- Address split: offset = 2 + log2(BLOCKS) low bits, then index = log2(SETS) bits, tag = remaining upper bits.
- Arrays (no reset):
  - tag array: SETS x tag;
  - valid bits: SETS x 1;
  - data array: SETS x BLOCKS x INST_WIDTH.
  - All read combinationally on i_addr index.
- hit = i_re & state==IDLE & valid[index] & tag[index]==addr tag.
- o_busy = (i_re & ~hit) | state!=IDLE.
  - Combinational; hit costs zero latency, and o_inst is valid in the same cycle.
- o_inst is a don't-care when o_busy=1.
- FSM states: INVAL, IDLE, FILL, DONE.
  - INVAL: clears valid[sweep], one set per cycle. sweep counts 0..SETS-1, then goes to IDLE. o_busy=1 throughout.
  - IDLE: on i_re & miss, latches the line address (tag+index) and goes to FILL with word counter=0. On i_flush, goes to INVAL (sweep=0). If i_re & miss & i_flush occur together, flush wins.
  - FILL:
    - o_mem_re=1; o_mem_addr = {line addr, word counter, 2'b00}.
    - On i_mem_ack, writes i_mem_data to data[index][counter] and increments the counter.
    - Ack on the last word → DONE.
    - Arbitrary ack latency; o_mem_addr is stable until ack.
  - DONE: writes tag[index] and sets valid[index]=1, then goes to IDLE (or INVAL if a flush is pending).
- Miss penalty with 1-cycle ack: BLOCKS + 2 cycles, then a hit in the following IDLE cycle.
- Boundary conditions:
  - i_addr or i_re changes during FILL: the fill completes for the latched line. IDLE then re-evaluates the current address and may miss again.
  - i_flush during FILL/DONE: recorded in flush_pending. The fill completes and the line is written, then INVAL sweeps it. flush_pending is cleared on entering INVAL.
  - i_flush during INVAL: restarts the sweep at 0.
  - Conflict miss (same index, different tag): the line is overwritten; valid stays 0 for that index from the first FILL write until DONE.
  - i_mem_ack while o_mem_re=0: ignored.
- Reset (asynchronous, any state, including mid-fill):
  - state=INVAL, sweep=0, word counter=0, flush_pending=0.
  - o_mem_re=0, o_mem_addr=0.
  - o_busy=1 (combinational from state).
  - An in-flight memory read is abandoned; the memory side must tolerate a dropped request.

Optional Feature:
- RV_ICACHE_STATS_EN defined:
  - adds outputs o_hit_count[31:0] and o_miss_count[31:0];
  - counters reset to 0 and wrap at 2^32;
  - hit increments on every IDLE cycle with hit;
  - miss increments once per IDLE→FILL transition;
  - i_flush does not clear the counters.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Config package: RV_ICACHE_BLOCKS, RV_ICACHE_SETS.
- Types package: InstAddr, Inst.
- New shared typedefs: ICacheTag, ICacheIndex, ICacheOffset, and the FSM enum ICacheState (also used by the bench).
- One sub-module, inst_cache_tag_ram: tag + valid storage, with async read, sync write, and single-cycle valid clear by index. The data array stays inline.

Test Plan:
- Reset, then i_re=1 on addr 0x0 → o_busy=1 for exactly 64 INVAL cycles, then the miss begins; no o_mem_re during the sweep.
- Cold miss at 0x100 (BLOCKS=4), mem ack 1 cycle, memory[a]=a^0xA5A5A5A5:
  - o_mem_addr sequence is 0x100, 0x104, 0x108, 0x10C;
  - busy clears 6 cycles after request;
  - o_inst[0..3] = 0xA5A5A4A5, 0xA5A5A4A1, 0xA5A5A4AD, 0xA5A5A4A9;
  - a repeated lookup at 0x108 hits with o_busy=0 in the same cycle.
- Conflict: fill 0x100, then access 0x100+SETS*16=0x500 → miss and refill; then 0x100 → miss again.
- Variable latency: ack after 3 wait cycles per word → o_mem_addr is held each wait; fill takes 4*4+2 cycles.
- i_flush pulse during the 2nd fill word → fill completes, DONE, INVAL sweep of 64 cycles, then 0x100 misses.
- Assert i_reset asynchronously mid-FILL → o_mem_re drops before the next clock edge, the sweep restarts, and the previously filling line misses afterwards.
